// File: rtl/conv_dw_pkg.sv
// Shared arithmetic helpers and weight-map geometry for the depthwise convolution stream.
package conv_dw_pkg;

  function automatic int taps(input int k);
    return k * k;
  endfunction

  // Words per channel in the weight map: K*K taps followed by one bias word.
  function automatic int wpc(input int k);
    return k * k + 1;
  endfunction

  function automatic int acc_w(input int dw, input int ww, input int k);
    return dw + ww + $clog2(k * k + 1);
  endfunction

  // Round half up (skipped when shift is 0), arithmetic shift, then clamp to dw-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift, input int dw);
    logic signed [63:0] v, hi, lo;
    v = acc;
    if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
    v = v >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_dw_line_buffer.sv
// K-1 row buffers indexed by column; presents a K-tall pixel column (top row first) for the current column.
module conv_dw_line_buffer #(
  parameter int C      = 4,
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 32,
  parameter int CW     = $clog2(IMG_W)
) (
  input  logic                    clk,
  input  logic                    i_en,
  input  logic [CW-1:0]           i_col,
  input  logic [C*DATA_W-1:0]     i_pix,
  output logic [K*C*DATA_W-1:0]   o_col
);

  localparam int PW = C * DATA_W;

  // r_mem[j][col] holds the pixel from j+1 rows above the row currently streaming in.
  logic [PW-1:0] r_mem [K-1][IMG_W];

  always_comb begin
    o_col = '0;
    for (int ky = 0; ky < K - 1; ky++) begin
      o_col[ky*PW +: PW] = r_mem[K-2-ky][i_col];
    end
    o_col[(K-1)*PW +: PW] = i_pix;
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0][i_col] <= i_pix;
      for (int j = 1; j < K - 1; j++) begin
        r_mem[j][i_col] <= r_mem[j-1][i_col];
      end
    end
  end

endmodule

// File: rtl/conv_depthwise_2d_stream.sv
// Streaming depthwise KxK convolution: raster pixels in, strided valid-window results out.
// One global enable stalls counters, line buffers, window and both pipeline stages together.
module conv_depthwise_2d_stream
  import conv_dw_pkg::*;
#(
  parameter int C      = 4,
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int STRIDE = 1,
  parameter int SHIFT  = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [C*DATA_W-1:0]                in_data,
  input  logic                               wt_we,
  input  logic [$clog2(C*(K*K+1))-1:0]       wt_addr,
  input  logic [W_W-1:0]                     wt_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [C*DATA_W-1:0]                out_data,
  output logic                               out_last
);

  localparam int TAPS  = taps(K);
  localparam int WPC   = wpc(K);
  localparam int NW    = C * WPC;
  localparam int AW    = $clog2(NW);
  localparam int ACC_W = acc_w(DATA_W, W_W, K);
  localparam int PW    = C * DATA_W;
  localparam int OW    = (IMG_W - K) / STRIDE + 1;
  localparam int OH    = (IMG_H - K) / STRIDE + 1;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(K - 1 + (OW - 1) * STRIDE);
  localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1 + (OH - 1) * STRIDE);

  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  logic                      w_en;
  logic                      w_accept;
  logic                      w_fire;
  logic                      w_last_pos;
  logic [CW-1:0]             w_col_off;
  logic [RW-1:0]             w_row_off;
  logic [K*PW-1:0]           w_column;

  logic signed [DATA_W-1:0]  r_win [C][K][K];
  logic                      r_win_vld;
  logic                      r_win_last;
  logic signed [W_W-1:0]     r_wt [NW];
  logic signed [ACC_W-1:0]   w_acc [C];
  logic signed [ACC_W-1:0]   r_acc [C];
  logic                      r_acc_vld;
  logic                      r_acc_last;
  logic                      r_out_valid;
  logic [PW-1:0]             r_out_data;
  logic                      r_out_last;

  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en;
  assign w_accept  = in_valid && w_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  // With STRIDE limited to 1 or 2, the stride phase is just the LSB of the offset.
  assign w_col_off  = r_col - COL_FIRST;
  assign w_row_off  = r_row - ROW_FIRST;
  assign w_fire     = (r_col >= COL_FIRST) && (r_row >= ROW_FIRST) &&
                      ((STRIDE == 1) || (!w_col_off[0] && !w_row_off[0]));
  assign w_last_pos = (r_col == COL_LAST) && (r_row == ROW_LAST);

  conv_dw_line_buffer #(
    .C      (C),
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W),
    .CW     (CW)
  ) u_line_buffer (
    .clk   (clk),
    .i_en  (w_accept),
    .i_col (r_col),
    .i_pix (in_data),
    .o_col (w_column)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wt <= '{default: '0};
    end else if (wt_we && ({1'b0, wt_addr} < (AW+1)'(NW))) begin
      r_wt[wt_addr] <= wt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win      <= '{default: '0};
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end else if (w_en) begin
      r_win_vld  <= w_accept && w_fire;
      r_win_last <= w_accept && w_last_pos;
      if (w_accept) begin
        for (int c = 0; c < C; c++) begin
          for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K - 1; kx++) begin
              r_win[c][ky][kx] <= r_win[c][ky][kx+1];
            end
            r_win[c][ky][K-1] <= w_column[ky*PW + c*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Each product is formed at full accumulator width so the tree sum never wraps.
  always_comb begin
    w_acc = '{default: '0};
    for (int c = 0; c < C; c++) begin
      w_acc[c] = ACC_W'(r_wt[c*WPC + TAPS]);
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          w_acc[c] = w_acc[c] + ACC_W'(r_win[c][ky][kx]) * ACC_W'(r_wt[c*WPC + ky*K + kx]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '{default: '0};
      r_acc_vld  <= 1'b0;
      r_acc_last <= 1'b0;
    end else if (w_en) begin
      r_acc_vld  <= r_win_vld;
      r_acc_last <= r_win_vld && r_win_last;
      if (r_win_vld) r_acc <= w_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_acc_vld;
      r_out_last  <= r_acc_vld && r_acc_last;
      if (r_acc_vld) begin
        for (int c = 0; c < C; c++) begin
          r_out_data[c*DATA_W +: DATA_W] <= DATA_W'(round_sat(64'(r_acc[c]), SHIFT, DATA_W));
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_depthwise_2d_stream.sv
// Directed bench: per-frame golden convolution model feeds an expectation queue checked on every output beat.
module tb_conv_depthwise_2d_stream;

  localparam int C      = 4;
  localparam int DATA_W = 8;
  localparam int W_W    = 8;
  localparam int K      = 3;
  localparam int IMG_W  = 6;
  localparam int IMG_H  = 6;
  localparam int STRIDE = 2;
  localparam int SHIFT  = 1;
  localparam int WPC    = K * K + 1;
  localparam int AW     = $clog2(C * WPC);
  localparam int PW     = C * DATA_W;
  localparam int OW     = (IMG_W - K) / STRIDE + 1;
  localparam int OH     = (IMG_H - K) / STRIDE + 1;
  localparam int NPIX   = IMG_W * IMG_H;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          wt_we;
  logic [AW-1:0] wt_addr;
  logic [W_W-1:0] wt_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_last;

  conv_depthwise_2d_stream #(
    .C(C), .DATA_W(DATA_W), .W_W(W_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .STRIDE(STRIDE), .SHIFT(SHIFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] data;
    logic          last;
    int            pix;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            frame [IMG_H][IMG_W][C];
  int            wt [C][K][K];
  int            bias [C];
  int            acc_edge [NPIX];
  exp_t          expq [$];
  exp_t          e_cur;
  logic [PW-1:0] got [$];
  bit            chk_lat = 0;
  bit            bp_en = 0;
  bit            hold = 0;
  logic [PW-1:0] hold_data;
  logic          hold_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  function automatic int rs(input longint acc);
    longint v;
    v = acc;
    if (SHIFT > 0) v = v + (longint'(1) <<< (SHIFT - 1));
    v = v >>> SHIFT;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  // Golden model: direct strided valid convolution over the stored frame.
  task automatic build_expected();
    exp_t e;
    for (int oy = 0; oy < OH; oy++) begin
      for (int ox = 0; ox < OW; ox++) begin
        e.data = '0;
        for (int c = 0; c < C; c++) begin
          longint acc;
          acc = bias[c];
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              acc += wt[c][ky][kx] * frame[oy*STRIDE+ky][ox*STRIDE+kx][c];
          e.data[c*DATA_W +: DATA_W] = DATA_W'(rs(acc));
        end
        e.last = (oy == OH - 1) && (ox == OW - 1);
        e.pix  = (oy*STRIDE + K - 1) * IMG_W + ox*STRIDE + K - 1;
        expq.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("stall_valid", PW'(out_valid), PW'(1));
        check("stall_data", out_data, hold_data);
        check("stall_last", PW'(out_last), PW'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output got %h want none", out_data);
        end else begin
          e_cur = expq.pop_front();
          check("out_data", out_data, e_cur.data);
          check("out_last", PW'(out_last), PW'(e_cur.last));
          if (chk_lat) check("latency", PW'(cyc - acc_edge[e_cur.pix]), PW'(2));
        end
        got.push_back(out_data);
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wt_write(input int a, input int v);
    wt_addr = AW'(a);
    wt_data = W_W'(v);
    wt_we   = 1'b1;
    tick();
    wt_we   = 1'b0;
  endtask

  task automatic load_weights();
    for (int c = 0; c < C; c++) begin
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          wt_write(c*WPC + ky*K + kx, wt[c][ky][kx]);
      wt_write(c*WPC + K*K, bias[c]);
    end
  endtask

  task automatic send(input int npix);
    bit acc;
    int n;
    for (int p = 0; p < npix; p++) begin
      for (int c = 0; c < C; c++)
        in_data[c*DATA_W +: DATA_W] = DATA_W'(frame[p / IMG_W][p % IMG_W][c]);
      in_valid = 1'b1;
      acc = 0;
      n = 0;
      while (!acc && n < 64) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1;
          acc_edge[p] = cyc + 1;
        end
        tick();
        n++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got none want pixel %0d", p);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain_empty", PW'(expq.size()), PW'(0));
    repeat (3) tick();
  endtask

  task automatic set_uniform(input int v0, input int v1, input int v2, input int v3);
    for (int r = 0; r < IMG_H; r++)
      for (int x = 0; x < IMG_W; x++) begin
        frame[r][x][0] = v0;
        frame[r][x][1] = v1;
        frame[r][x][2] = v2;
        frame[r][x][3] = v3;
      end
  endtask

  task automatic set_ramp();
    for (int r = 0; r < IMG_H; r++)
      for (int x = 0; x < IMG_W; x++) begin
        frame[r][x][0] = r*IMG_W + x;
        frame[r][x][1] = -(r*IMG_W + x);
        frame[r][x][2] = (r*IMG_W + x) * 3 - 50;
        frame[r][x][3] = ((r*IMG_W + x) * 37) % 200 - 100;
      end
  endtask

  task automatic set_ramp_kernels();
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++) begin
        wt[0][ky][kx] = 1;
        wt[1][ky][kx] = kx - ky;
        wt[2][ky][kx] = ky*3 + kx - 4;
        wt[3][ky][kx] = (ky == kx) ? 2 : -1;
      end
    bias[0] = 0;
    bias[1] = 5;
    bias[2] = -3;
    bias[3] = 10;
  endtask

  task automatic set_kernels_fill(input int v);
    for (int c = 0; c < C; c++) begin
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          wt[c][ky][kx] = v;
      bias[c] = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", PW'(out_valid), PW'(0));
    check("reset_out_data", out_data, PW'(0));
    check("reset_out_last", PW'(out_last), PW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", PW'(in_ready), PW'(1));
    tick();

    // Basic: all-ones kernels on uniform lanes, with per-output latency checks.
    set_kernels_fill(1);
    load_weights();
    set_uniform(1, 2, -1, 0);
    got.delete();
    build_expected();
    chk_lat = 1;
    send(NPIX);
    drain();
    chk_lat = 0;
    check("basic_count", PW'(got.size()), PW'(OW*OH));
    check("basic_first", got[0], 32'h00FC0905);
    check("basic_fourth", got[3], 32'h00FC0905);

    // Saturation on lanes 0/1, rounding of +3/-3 with a centre tap on lanes 2/3.
    set_kernels_fill(127);
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++) begin
        wt[2][ky][kx] = (ky == 1 && kx == 1) ? 1 : 0;
        wt[3][ky][kx] = (ky == 1 && kx == 1) ? 1 : 0;
      end
    load_weights();
    set_uniform(127, -128, 3, -3);
    got.delete();
    build_expected();
    send(NPIX);
    drain();
    check("sat_round_first", got[0], 32'hFF02807F);

    // Ramp frame, distinct kernels per lane, no stall.
    set_ramp_kernels();
    load_weights();
    set_ramp();
    got.delete();
    build_expected();
    send(NPIX);
    drain();
    check("ramp_count", PW'(got.size()), PW'(OW*OH));
    check("ramp_lane0_first", PW'(got[0][7:0]), PW'(32));

    // Same frame under random backpressure.
    got.delete();
    build_expected();
    bp_en = 1;
    send(NPIX);
    drain();
    bp_en = 0;
    out_ready = 1'b1;
    repeat (2) tick();
    check("bp_count", PW'(got.size()), PW'(OW*OH));

    // Mid-frame reset while an output is held by the sink.
    build_expected();
    send(17);
    out_ready = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", PW'(out_valid), PW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", PW'(out_valid), PW'(0));
    check("midrst_out_data", out_data, PW'(0));
    check("midrst_out_last", PW'(out_last), PW'(0));
    expq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", PW'(in_ready), PW'(1));
    tick();

    // Weights must read back as zero after reset.
    set_kernels_fill(0);
    got.delete();
    build_expected();
    send(NPIX);
    drain();
    check("zero_wt_count", PW'(got.size()), PW'(OW*OH));

    // Reloaded weights give the golden frame again.
    set_ramp_kernels();
    load_weights();
    got.delete();
    build_expected();
    send(NPIX);
    drain();
    check("reload_lane0_first", PW'(got[0][7:0]), PW'(32));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
